// File: rtl/sata_axi_pkg.sv
// sata_axi_pkg: shared FSM encoding and fixed AXI burst attributes for the register master.
package sata_axi_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_ADDR,
        ST_W_RESP,
        ST_R_ADDR,
        ST_R_DATA,
        ST_RSP
    } state_t;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_SIZE_4B    = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_TIMEOUT   = 2'b11;
endpackage

// File: rtl/axi_reg_master.sv
// axi_reg_master: single-outstanding AXI3 register master turning a simple command
// handshake into one 32-bit read or write, with a bounded wait on the response channel.
module axi_reg_master
    import sata_axi_pkg::*;
#(
    parameter logic [11:0] ID      = 12'h000,
    parameter int          TIMEOUT = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [11:0] AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [1:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [11:0] WID,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [11:0] BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic [11:0] ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [1:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [11:0] RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);
    state_t      state;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        expired;
    logic        aw_done;
    logic        w_done;
    logic        unused_ok;

    assign AWID    = ID;
    assign WID     = ID;
    assign ARID    = ID;
    assign AWLEN   = AXI_LEN_SINGLE;
    assign ARLEN   = AXI_LEN_SINGLE;
    assign AWSIZE  = AXI_SIZE_4B;
    assign ARSIZE  = AXI_SIZE_4B;
    assign AWBURST = AXI_BURST_INCR;
    assign ARBURST = AXI_BURST_INCR;
    assign AWADDR  = addr;
    assign ARADDR  = addr;
    assign WLAST   = WVALID;
    assign unused_ok = ^{RID, BID, RLAST, cmd_addr[1:0]};

    // A zero TIMEOUT means wait forever on B/R.
    assign expired = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));
    assign aw_done = !AWVALID || AWREADY;
    assign w_done  = !WVALID || WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            AWVALID     <= 1'b0;
            WVALID      <= 1'b0;
            ARVALID     <= 1'b0;
            BREADY      <= 1'b0;
            RREADY      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_resp    <= 2'b00;
            rsp_rdata   <= 32'h0;
            cnt         <= 32'h0;
            addr        <= 32'h0;
            WDATA       <= 32'h0;
            WSTRB       <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr      <= {cmd_addr[31:2], 2'b00};
                        WDATA     <= cmd_wdata;
                        WSTRB     <= cmd_wstb;
                        AWVALID   <= !cmd_rnw;
                        WVALID    <= !cmd_rnw;
                        ARVALID   <= cmd_rnw;
                        state     <= cmd_rnw ? ST_R_ADDR : ST_W_ADDR;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_W_ADDR: begin
                    if (AWVALID && AWREADY) AWVALID <= 1'b0;
                    if (WVALID && WREADY) WVALID <= 1'b0;
                    if (aw_done && w_done) begin
                        BREADY <= 1'b1;
                        cnt    <= 32'h0;
                        state  <= ST_W_RESP;
                    end
                end
                ST_R_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        cnt     <= 32'h0;
                        state   <= ST_R_DATA;
                    end
                end
                ST_W_RESP, ST_R_DATA: begin
                    // A beat landing on the expiry cycle still wins over the timeout.
                    if (state == ST_W_RESP ? BVALID : RVALID) begin
                        BREADY      <= 1'b0;
                        RREADY      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_resp    <= state == ST_W_RESP ? BRESP : RRESP;
                        rsp_rdata   <= state == ST_W_RESP ? 32'h0 : RDATA;
                        state       <= ST_RSP;
                    end else if (expired) begin
                        BREADY      <= 1'b0;
                        RREADY      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_resp    <= RESP_TIMEOUT;
                        rsp_rdata   <= 32'h0;
                        state       <= ST_RSP;
                    end else begin
                        cnt <= cnt + 32'h1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
